// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and MDU state type for the alu_mdu execute stage
// Contents: ALU opcode codes, md_op codes, MDU FSM state enum. No ports.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBU = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;

  localparam logic [2:0] MD_MULTU = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_DIVU  = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_e;

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit with HI/LO registers
// Ports: clk, reset (sync, active-high); start_i/op_i launch an op with operands a_i/b_i;
//        busy_o high while iterating; done_o one-cycle pulse when mult/div updates hi_o/lo_o.
// Build option: ALU_MDU_SIGNED_EN enables signed mult/div (op 001/011); otherwise they run unsigned.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;    // running product high half / partial remainder
  logic [WIDTH-1:0] shr_q;    // multiplier bits shifting out / dividend in, quotient out
  logic [WIDTH-1:0] dvs_q;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_raw_q;  // unmodified A, returned as remainder on divide by zero
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_div_q, bzero_q, done_q;
  logic             last_step;

  assign last_step = (state_q == MD_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // Operand magnitudes: the iteration always works on unsigned values.
  logic [WIDTH-1:0] a_mag, b_mag;
`ifdef ALU_MDU_SIGNED_EN
  logic signed_op, a_neg, b_neg, neg_q, rneg_q;
  always_comb begin
    signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    a_neg     = signed_op && a_i[WIDTH-1];
    b_neg     = signed_op && b_i[WIDTH-1];
    a_mag     = a_neg ? -a_i : a_i;
    b_mag     = b_neg ? -b_i : b_i;
  end
`else
  assign a_mag = a_i;
  assign b_mag = b_i;
`endif

  // One shift-add (multiply) or restoring (divide) step.
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH+1:0] div_trial;
  logic [WIDTH-1:0] step_acc, step_shr;
  logic             div_ok;
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {acc_q, shr_q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, dvs_q};
    div_ok    = ~div_trial[WIDTH+1];
    if (is_div_q) begin
      step_acc = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_shr = {shr_q[WIDTH-2:0], div_ok};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_shr = {mul_sum[0], shr_q[WIDTH-1:1]};
    end
  end

  // Final-step result, with sign fix folded into the same cycle.
  logic [WIDTH-1:0] res_hi, res_lo;
  always_comb begin
    res_hi = step_acc;
    res_lo = step_shr;
`ifdef ALU_MDU_SIGNED_EN
    if (!is_div_q && neg_q) begin
      {res_hi, res_lo} = -{step_acc, step_shr};
    end else if (is_div_q) begin
      if (neg_q)  res_lo = -step_shr;
      if (rneg_q) res_hi = -step_acc;
    end
`endif
    if (is_div_q && bzero_q) begin
      res_hi = a_raw_q;
      res_lo = '1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start_i && !op_i[2]) state_d = MD_RUN;
      MD_RUN:  if (last_step)           state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q == MD_RUN);
    done_o = done_q;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      shr_q    <= '0;
      dvs_q    <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      bzero_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MDU_SIGNED_EN
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q == MD_IDLE) begin
        // Starts are only honoured in IDLE; a start during RUN is dropped.
        if (start_i) begin
          case (op_i)
            MD_MTHI: hi_q <= a_i;
            MD_MTLO: lo_q <= a_i;
            default: begin
              if (!op_i[2]) begin
                cnt_q    <= '0;
                acc_q    <= '0;
                shr_q    <= op_i[1] ? a_mag : b_mag;
                dvs_q    <= op_i[1] ? b_mag : a_mag;
                a_raw_q  <= a_i;
                is_div_q <= op_i[1];
                bzero_q  <= (b_i == '0);
`ifdef ALU_MDU_SIGNED_EN
                neg_q    <= a_neg ^ b_neg;
                rneg_q   <= a_neg;
`endif
              end
            end
          endcase
        end
      end else begin
        acc_q <= step_acc;
        shr_q <= step_shr;
        cnt_q <= cnt_q + 1'b1;
        if (last_step) begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - MIPS execute-stage ALU plus iterative multiply/divide unit
// Ports: clk, reset (sync, active-high); A, B, Op -> C, Over (combinational ALU);
//        md_start, md_op -> md_busy, md_done, hi, lo (multi-cycle MDU).
// Build option: ALU_MDU_SIGNED_EN enables signed mult/div inside mdu_iter.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic [WIDTH-1:0] C,
  output logic             Over,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff;

  assign shamt = A[SHAMT_W-1:0];
  assign sum   = A + B;
  assign diff  = A - B;

  always_comb begin
    C    = '0;
    Over = 1'b0;
    case (Op)
      ALU_ADD: begin
        C    = sum;
        Over = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_ADDU: C = sum;
      ALU_SUB: begin
        C    = diff;
        Over = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUBU: C = diff;
      ALU_SLL:  C = B << shamt;
      ALU_SRL:  C = B >> shamt;
      ALU_SRA:  C = WIDTH'($signed(B) >>> shamt);
      ALU_AND:  C = A & B;
      ALU_OR:   C = A | B;
      ALU_XOR:  C = A ^ B;
      ALU_NOR:  C = ~(A | B);
      ALU_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
      default:  C = '0;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk     (clk),
    .reset   (reset),
    .start_i (md_start),
    .op_i    (md_op),
    .a_i     (A),
    .b_i     (B),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - scoreboard bench for alu_mdu (directed ALU and MDU vectors)
module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B, C, hi, lo;
  logic [3:0]  Op;
  logic        Over, md_start, md_busy, md_done;
  logic [2:0]  md_op;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        ov;
  } alu_vec_t;
  alu_vec_t vecs[15];

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op), .C(C), .Over(Over),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done),
    .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every md_done pulse must match the oldest expected {hi,lo}.
  always @(negedge clk) begin
    if (!reset && md_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: md_done got 1 expected 0 (no pending op)");
      end else begin
        mon_e = exp_q.pop_front();
        check("md_hi", {32'h0, hi}, {32'h0, mon_e[63:32]});
        check("md_lo", {32'h0, lo}, {32'h0, mon_e[31:0]});
      end
    end
  end

  task automatic md_go(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    md_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!md_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'h0, md_done}, 64'h1);
  endtask

  initial begin
    int busy_cnt, done_at, done_cnt;

    vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vecs[1]  = '{ALU_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[2]  = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vecs[3]  = '{ALU_SUBU, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{ALU_SLL,  32'h00000004, 32'h00000001, 32'h00000010, 1'b0};
    vecs[5]  = '{ALU_SRL,  32'h00000024, 32'h80000000, 32'h08000000, 1'b0};
    vecs[6]  = '{ALU_SRA,  32'h00000004, 32'h80000000, 32'hF8000000, 1'b0};
    vecs[7]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[8]  = '{ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
    vecs[9]  = '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vecs[10] = '{ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0};
    vecs[11] = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[12] = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[13] = '{4'b1101,  32'h00000001, 32'h00000001, 32'h00000000, 1'b0};
    vecs[14] = '{ALU_ADD,  32'h00000001, 32'h00000001, 32'h00000002, 1'b0};

    reset = 1'b1; md_start = 1'b0; md_op = 3'b000; A = '0; B = '0; Op = '0;
    repeat (3) @(negedge clk);
    check("rst_hi",   {32'h0, hi}, 64'h0);
    check("rst_lo",   {32'h0, lo}, 64'h0);
    check("rst_busy", {63'h0, md_busy}, 64'h0);
    check("rst_done", {63'h0, md_done}, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      Op = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
      #1;
      check($sformatf("alu%0d_C", i),    {32'h0, C},    {32'h0, vecs[i].c});
      check($sformatf("alu%0d_Over", i), {63'h0, Over}, {63'h0, vecs[i].ov});
    end

    // multu timing: busy for exactly 32 cycles, done in cycle k+33.
    exp_q.push_back({32'h00000001, 32'hFFFFFFFE});
    md_go(MD_MULTU, 32'hFFFFFFFF, 32'h00000002);
    busy_cnt = 0; done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      if (md_busy) busy_cnt++;
      if (md_done && done_at == 0) done_at = i;
      @(negedge clk);
    end
    check("multu_busy_cycles", 64'(busy_cnt), 64'd32);
    check("multu_done_cycle",  64'(done_at),  64'd33);

    exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
    md_go(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max_timeout");

    exp_q.push_back({32'h00000001, 32'h00000000});
    md_go(MD_MULTU, 32'h00010000, 32'h00010000);
    wait_done("multu_pow_timeout");

`ifdef ALU_MDU_SIGNED_EN
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
`else
    exp_q.push_back({32'h00000004, 32'hFFFFFFF1});
`endif
    md_go(MD_MULT, 32'hFFFFFFFD, 32'h00000005);
    wait_done("mult_timeout");

`ifdef ALU_MDU_SIGNED_EN
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
`else
    exp_q.push_back({32'h00000001, 32'h7FFFFFFC});
`endif
    md_go(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done("div_neg_timeout");

`ifdef ALU_MDU_SIGNED_EN
    exp_q.push_back({32'h00000001, 32'hFFFFFFFD});
`else
    exp_q.push_back({32'h00000007, 32'h00000000});
`endif
    md_go(MD_DIV, 32'h00000007, 32'hFFFFFFFE);
    wait_done("div_negb_timeout");

`ifdef ALU_MDU_SIGNED_EN
    exp_q.push_back({32'h00000000, 32'h80000000});
`else
    exp_q.push_back({32'h80000000, 32'h00000000});
`endif
    md_go(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_min_timeout");

    exp_q.push_back({32'h00000005, 32'hFFFFFFFF});
    md_go(MD_DIVU, 32'h00000005, 32'h00000000);
    wait_done("divu_zero_timeout");

    // mthi during a running divu must be dropped.
    exp_q.push_back({32'h00000002, 32'h0000000E});
    md_go(MD_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    md_start = 1'b1; md_op = MD_MTHI; A = 32'hDEADBEEF;
    @(negedge clk);
    md_start = 1'b0;
    check("ignored_start_busy", {63'h0, md_busy}, 64'h1);
    wait_done("divu_ignored_timeout");

    // Reset mid-run: op aborted, hi/lo cleared, no done.
    md_go(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi",   {32'h0, hi}, 64'h0);
    check("abort_lo",   {32'h0, lo}, 64'h0);
    check("abort_busy", {63'h0, md_busy}, 64'h0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    md_go(MD_MTLO, 32'h00001234, 32'h0);
    check("mtlo_lo",   {32'h0, lo}, 64'h1234);
    check("mtlo_busy", {63'h0, md_busy}, 64'h0);
    md_go(MD_MTHI, 32'h0000ABCD, 32'h0);
    check("mthi_hi",   {32'h0, hi}, 64'hABCD);
    check("mthi_busy", {63'h0, md_busy}, 64'h0);

    // Back-to-back: new start issued in the md_done cycle.
    exp_q.push_back({32'h00000000, 32'h0000000C});
    md_go(MD_MULTU, 32'd3, 32'd4);
    wait_done("b2b_first_timeout");
    md_start = 1'b1; md_op = MD_DIVU; A = 32'd100; B = 32'd7;
    exp_q.push_back({32'h00000002, 32'h0000000E});
    @(negedge clk);
    md_start = 1'b0;
    check("b2b_accept_busy", {63'h0, md_busy}, 64'h1);
    wait_done("b2b_second_timeout");

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
